// File: rtl/tc_sram_tiled_rmw.sv
// Tiled single-port SRAM with byte-enable writes done as read-modify-write.
// The memory is a NumRows x NumCols grid of fixed-size macro tiles. A partial
// byte-enable write stalls for one cycle to fetch the old word, then merges it.

// Behavioural model of one hard macro tile: 1-cycle read, no byte enables.
module tc_sram_macro #(
    parameter int unsigned Words = 256,
    parameter int unsigned Width = 32,
    parameter int unsigned Aw    = 8
) (
    input  logic             clk_i,
    input  logic             ce_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Words];
    logic [Width-1:0] rdata_q;

    // Array write or registered read; rdata holds between reads
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

module tc_sram_tiled_rmw #(
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned DataWidth  = 128,
    parameter int unsigned ByteWidth  = 8,
    parameter int unsigned MacroWords = 256,
    parameter int unsigned MacroWidth = 32,
    parameter int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth    = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 oor_o
);

    localparam int unsigned NumRows  = (NumWords + MacroWords - 1) / MacroWords;
    localparam int unsigned NumCols  = (DataWidth + MacroWidth - 1) / MacroWidth;
    localparam int unsigned TileAw   = (MacroWords > 1) ? $clog2(MacroWords) : 1;
    localparam int unsigned RowW     = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned PadWidth = NumCols * MacroWidth;

    typedef enum logic {
        Idle,
        Merge
    } state_e;

    state_e state_q, state_d;

    // Request decode
    logic              in_range, be_full, be_none, partial_wr;
    logic [RowW-1:0]   req_row;
    logic [TileAw-1:0] req_taddr;

    assign in_range   = 32'(addr_i) < NumWords;
    assign be_full    = &be_i;
    assign be_none    = ~|be_i;
    assign partial_wr = in_range && we_i && !be_full && !be_none;
    assign req_row    = RowW'(32'(addr_i) / MacroWords);
    assign req_taddr  = TileAw'(32'(addr_i) % MacroWords);

    // Access issued to the tile grid this cycle
    logic                acc_ce, acc_we;
    logic [RowW-1:0]     acc_row;
    logic [TileAw-1:0]   acc_taddr;
    logic [PadWidth-1:0] acc_wdata;
    logic                rd_issue, oor_issue, merge_start;

    // Partial write captured at the stall cycle so MERGE does not depend on inputs
    logic [RowW-1:0]      m_row_q;
    logic [TileAw-1:0]    m_taddr_q;
    logic [DataWidth-1:0] m_wdata_q;
    logic [BeWidth-1:0]   m_be_q;

    // Read return pipeline
    logic                 rvalid_q, oor_q, rd_oor_q;
    logic [RowW-1:0]      rd_row_q;
    logic [DataWidth-1:0] rdata_hold_q;

    logic [PadWidth-1:0]  row_rdata [NumRows];
    logic [PadWidth-1:0]  row_word;
    logic [DataWidth-1:0] old_word, rd_word, be_mask, merged;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: partial writes take a MERGE cycle, everything else stays in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle:    if (req_i && partial_wr) state_d = Merge;
            Merge:   state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    // Outputs: grant and tile access; nothing is granted or written while in reset
    always_comb begin
        gnt_o       = 1'b0;
        acc_ce      = 1'b0;
        acc_we      = 1'b0;
        acc_row     = req_row;
        acc_taddr   = req_taddr;
        acc_wdata   = PadWidth'(wdata_i);
        rd_issue    = 1'b0;
        oor_issue   = 1'b0;
        merge_start = 1'b0;
        if (rst_ni) begin
            case (state_q)
                Idle: begin
                    if (req_i) begin
                        if (!in_range) begin
                            gnt_o     = 1'b1;
                            oor_issue = 1'b1;
                            rd_issue  = !we_i;
                        end else if (!we_i) begin
                            gnt_o    = 1'b1;
                            acc_ce   = 1'b1;
                            rd_issue = 1'b1;
                        end else if (be_full) begin
                            gnt_o  = 1'b1;
                            acc_ce = 1'b1;
                            acc_we = 1'b1;
                        end else if (be_none) begin
                            gnt_o = 1'b1;
                        end else begin
                            acc_ce      = 1'b1;
                            merge_start = 1'b1;
                        end
                    end
                end
                Merge: begin
                    gnt_o     = 1'b1;
                    acc_ce    = 1'b1;
                    acc_we    = 1'b1;
                    acc_row   = m_row_q;
                    acc_taddr = m_taddr_q;
                    acc_wdata = PadWidth'(merged);
                end
                default: ;
            endcase
        end
    end

    // Merge-operand capture and read-return pipeline
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_row_q      <= '0;
            m_taddr_q    <= '0;
            m_wdata_q    <= '0;
            m_be_q       <= '0;
            rvalid_q     <= 1'b0;
            oor_q        <= 1'b0;
            rd_oor_q     <= 1'b0;
            rd_row_q     <= '0;
            rdata_hold_q <= '0;
        end else begin
            rvalid_q <= rd_issue;
            oor_q    <= oor_issue;
            rd_oor_q <= oor_issue;
            if (acc_ce && !acc_we) rd_row_q <= acc_row;
            if (merge_start) begin
                m_row_q   <= req_row;
                m_taddr_q <= req_taddr;
                m_wdata_q <= wdata_i;
                m_be_q    <= be_i;
            end
            if (rvalid_q) rdata_hold_q <= rd_word;
        end
    end

    // Tile grid: only the addressed row is chip-enabled
    for (genvar r = 0; r < NumRows; r++) begin : g_row
        logic                row_ce;
        logic [PadWidth-1:0] row_rd;
        assign row_ce       = acc_ce && (acc_row == RowW'(r));
        assign row_rdata[r] = row_rd;
        for (genvar c = 0; c < NumCols; c++) begin : g_col
            tc_sram_macro #(
                .Words (MacroWords),
                .Width (MacroWidth),
                .Aw    (TileAw)
            ) u_tile (
                .clk_i   (clk_i),
                .ce_i    (row_ce),
                .we_i    (acc_we),
                .addr_i  (acc_taddr),
                .wdata_i (acc_wdata[c*MacroWidth +: MacroWidth]),
                .rdata_o (row_rd[c*MacroWidth +: MacroWidth])
            );
        end
    end

    for (genvar i = 0; i < DataWidth; i++) begin : g_bemask
        assign be_mask[i] = m_be_q[i / ByteWidth];
    end

    if (PadWidth > DataWidth) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^row_word[PadWidth-1:DataWidth];
    end

    // Read data path: old word for merges, zero for out-of-range reads, hold otherwise
    always_comb begin
        row_word = row_rdata[rd_row_q];
        old_word = row_word[DataWidth-1:0];
        merged   = (m_wdata_q & be_mask) | (old_word & ~be_mask);
        rd_word  = rd_oor_q ? '0 : old_word;
    end

    assign rvalid_o = rvalid_q;
    assign oor_o    = oor_q;
    assign rdata_o  = rvalid_q ? rd_word : rdata_hold_q;

    // Requester must hold a stalled request unchanged until granted
    a_stall_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> req_i);
    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> ($stable(we_i) && $stable(addr_i) && $stable(wdata_i) && $stable(be_i)));
    a_params : assert property (@(posedge clk_i)
        (NumWords >= 1) && (DataWidth >= 1) && (ByteWidth >= 1) && (MacroWords >= 1) &&
        (MacroWidth >= 1) && ((MacroWords & (MacroWords - 1)) == 0));

endmodule

// File: tb/tb_tc_sram_tiled_rmw.sv
// Bench for tc_sram_tiled_rmw: a default 1024x128 instance and a 600x72
// instance (non power-of-two depth, padded column), checked every cycle
// against a transaction-level memory model, plus literal directed checks.
module tb_tc_sram_tiled_rmw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default geometry
    logic         rst_a, req_a, we_a, gnt_a, rv_a, oor_a;
    logic [9:0]   addr_a;
    logic [127:0] wd_a, rd_a;
    logic [15:0]  be_a;

    // Instance B: 600 x 72
    logic         rst_b, req_b, we_b, gnt_b, rv_b, oor_b;
    logic [9:0]   addr_b;
    logic [71:0]  wd_b, rd_b;
    logic [8:0]   be_b;

    tc_sram_tiled_rmw u_dut_a (
        .clk_i (clk), .rst_ni (rst_a), .req_i (req_a), .gnt_o (gnt_a), .we_i (we_a),
        .addr_i (addr_a), .wdata_i (wd_a), .be_i (be_a), .rvalid_o (rv_a),
        .rdata_o (rd_a), .oor_o (oor_a)
    );

    tc_sram_tiled_rmw #(
        .NumWords (600), .DataWidth (72), .ByteWidth (8), .MacroWords (256), .MacroWidth (32)
    ) u_dut_b (
        .clk_i (clk), .rst_ni (rst_b), .req_i (req_b), .gnt_o (gnt_b), .we_i (we_b),
        .addr_i (addr_b), .wdata_i (wd_b), .be_i (be_b), .rvalid_o (rv_b),
        .rdata_o (rd_b), .oor_o (oor_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input int d, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, expected %h", d, nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [127:0] mem [int];           // key = dut*4096 + word address
    int unsigned  NW  [2] = '{1024, 600};
    logic [15:0]  FULL[2] = '{16'hFFFF, 16'h01FF};
    int unsigned  wait_c [2];
    logic         exp_rv [2];
    logic         exp_oor[2];
    logic [127:0] exp_rd [2];
    logic [127:0] last_rd[2];

    function automatic logic [127:0] byte_merge(input logic [127:0] old, input logic [127:0] wd,
                                                input logic [15:0] be);
        logic [127:0] r = old;
        for (int b = 0; b < 16; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    logic         s_rst, s_req, s_we, s_gnt, s_rv, s_oor, s_part, s_eg;
    logic [9:0]   s_ad;
    logic [127:0] s_wd, s_rd;
    logic [15:0]  s_be;
    int           s_key;

    // Single compare process: every cycle, both instances
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            s_rst = d ? rst_b : rst_a;
            s_req = d ? req_b : req_a;
            s_we  = d ? we_b  : we_a;
            s_gnt = d ? gnt_b : gnt_a;
            s_rv  = d ? rv_b  : rv_a;
            s_oor = d ? oor_b : oor_a;
            s_ad  = d ? addr_b : addr_a;
            s_wd  = d ? 128'(wd_b) : wd_a;
            s_rd  = d ? 128'(rd_b) : rd_a;
            s_be  = d ? 16'(be_b) : be_a;
            if (!s_rst) begin
                chk(d, "reset_gnt", s_gnt, 0);
                chk(d, "reset_rvalid", s_rv, 0);
                chk(d, "reset_oor", s_oor, 0);
                chk(d, "reset_rdata", s_rd, 0);
                wait_c[d]  = 0;
                exp_rv[d]  = 1'b0;
                exp_oor[d] = 1'b0;
                last_rd[d] = '0;
            end else begin
                chk(d, "rvalid", s_rv, exp_rv[d]);
                chk(d, "oor", s_oor, exp_oor[d]);
                if (exp_rv[d]) last_rd[d] = exp_rd[d];
                chk(d, exp_rv[d] ? "rdata" : "rdata_hold", s_rd, last_rd[d]);
                // in-range partial writes need one extra cycle before grant
                s_part = s_req && s_we && (32'(s_ad) < NW[d]) && (s_be != 0) && (s_be != FULL[d]);
                s_eg   = s_req && (wait_c[d] == (s_part ? 1 : 0));
                chk(d, "gnt", s_gnt, s_eg);
                exp_rv[d]  = 1'b0;
                exp_oor[d] = 1'b0;
                if (s_eg) begin
                    wait_c[d] = 0;
                    s_key = d * 4096 + int'(s_ad);
                    if (32'(s_ad) >= NW[d]) begin
                        exp_oor[d] = 1'b1;
                        if (!s_we) begin
                            exp_rv[d] = 1'b1;
                            exp_rd[d] = '0;
                        end
                    end else if (!s_we) begin
                        exp_rv[d] = 1'b1;
                        exp_rd[d] = mem.exists(s_key) ? mem[s_key] : 'x;
                    end else if (s_be != 0) begin
                        mem[s_key] = byte_merge(mem.exists(s_key) ? mem[s_key] : '0, s_wd, s_be);
                    end
                end else if (s_req) begin
                    wait_c[d]++;
                end else begin
                    wait_c[d] = 0;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic op(input int d, input logic w, input logic [9:0] ad, input logic [127:0] wd,
                      input logic [15:0] be, output int unsigned stalls);
        stalls = 0;
        if (d == 0) begin
            req_a = 1'b1; we_a = w; addr_a = ad; wd_a = wd; be_a = be;
        end else begin
            req_b = 1'b1; we_b = w; addr_b = ad; wd_b = wd[71:0]; be_b = be[8:0];
        end
        forever begin
            @(negedge clk);
            if ((d == 0) ? gnt_a : gnt_b) break;
            stalls++;
            if (stalls > 4) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut%0d grant_timeout: no gnt after %0d cycles, required within 1", d, stalls);
                break;
            end
        end
        @(posedge clk); #1;
        if (d == 0) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd_lit(input int d, input logic [9:0] ad, input logic [127:0] exp, input string nm);
        int unsigned s;
        op(d, 1'b0, ad, '0, '0, s);
        chk(d, {nm, "_gnt_latency"}, s, 0);
        @(negedge clk);
        chk(d, {nm, "_rvalid"}, (d == 0) ? rv_a : rv_b, 1);
        chk(d, {nm, "_rdata"}, (d == 0) ? rd_a : 128'(rd_b), exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    int unsigned  s;
    logic [9:0]   ad;
    logic [127:0] wd;
    logic [15:0]  be;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = '0; wd_a = '0; be_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wd_b = '0; be_b = '0;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(0, "reset_gnt_lit", gnt_a, 0);
        chk(0, "reset_rdata_lit", rd_a, 0);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0;
        idle(1);

        // full-word write then read
        op(0, 1'b1, 10'd5, {16{8'hA5}}, 16'hFFFF, s);
        chk(0, "t1_write_gnt_latency", s, 0);
        rd_lit(0, 10'd5, {16{8'hA5}}, "t1");

        // partial write clears byte 0 only
        op(0, 1'b1, 10'd300, '1, 16'hFFFF, s);
        op(0, 1'b1, 10'd300, '0, 16'h0001, s);
        chk(0, "t2_partial_stall_cycles", s, 1);
        rd_lit(0, 10'd300, {{15{8'hFF}}, 8'h00}, "t2");

        // be == 0 is a single-cycle no-op
        op(0, 1'b1, 10'd7, 128'h77, 16'hFFFF, s);
        op(0, 1'b1, 10'd7, 128'hDEAD, 16'h0000, s);
        chk(0, "t6_be0_gnt_latency", s, 0);
        rd_lit(0, 10'd7, 128'h77, "t6");

        // 600 x 72: last word, then out-of-range accesses
        op(1, 1'b1, 10'd599, 128'(72'hC3_5A5A_1234_5678_9ABC), 16'h01FF, s);
        rd_lit(1, 10'd599, 128'(72'hC3_5A5A_1234_5678_9ABC), "t3_last");
        op(1, 1'b1, 10'd700, '1, 16'h0003, s);
        chk(1, "t3_oor_write_gnt_latency", s, 0);
        @(negedge clk);
        chk(1, "t3_oor_pulse", oor_b, 1);
        @(posedge clk); #1;
        rd_lit(1, 10'd700, '0, "t3_oor_read");
        rd_lit(1, 10'd599, 128'(72'hC3_5A5A_1234_5678_9ABC), "t3_unchanged");

        // reset during MERGE abandons the write
        op(0, 1'b1, 10'd10, 128'h1234, 16'hFFFF, s);
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'd10; wd_a = '1; be_a = 16'h0003;
        @(negedge clk);
        chk(0, "t5_stall", gnt_a, 0);
        @(posedge clk); #2;
        rst_a = 1'b0; req_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1;
        rd_lit(0, 10'd10, 128'h1234, "t5");

        // random write-then-read streams
        for (int i = 0; i < 100; i++) begin
            ad = 10'($urandom_range(0, 1023));
            wd = {$urandom, $urandom, $urandom, $urandom};
            be = (mem.exists(int'(ad)) && $urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
            op(0, 1'b1, ad, wd, be, s);
            op(0, 1'b0, ad, '0, '0, s);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        for (int i = 0; i < 40; i++) begin
            ad = 10'($urandom_range(0, 1023));
            wd = {$urandom, $urandom, $urandom, $urandom};
            be = (mem.exists(4096 + int'(ad)) || ad >= 10'd600) ? 16'($urandom_range(0, 511)) : 16'h01FF;
            op(1, 1'b1, ad, wd, be, s);
            op(1, 1'b0, ad, '0, '0, s);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
